// File: rtl/next_prime_gen_pkg.sv
// Shared types and constants for the next-prime generator: FSM encoding and
// the largest 16-bit prime.
package next_prime_gen_pkg;

  localparam logic [15:0] MAX_PRIME16 = 16'd65521;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_CHK   = 3'd2,
    S_REM   = 3'd3,
    S_NEXTD = 3'd4,
    S_NEXTC = 3'd5,
    S_DONE  = 3'd6
  } state_t;

endpackage

// File: rtl/next_prime_ctrl.sv
// Search controller: sequences candidate/divisor stepping and issues load
// enables to the datapath; owns the registered done flag.
module next_prime_ctrl
  import next_prime_gen_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic go,
  input  logic prime_hit,
  input  logic ge,
  input  logic r_zero,
  input  logic c_max,
  output logic ld_sw,
  output logic ld_init,
  output logic ld_r,
  output logic ld_sub,
  output logic ld_incd,
  output logic ld_nextc,
  output logic ld_prime,
  output logic ld_ovf,
  output logic stp,
  output logic busy
);

  state_t state, nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      stp   <= 1'b0;
    end else begin
      state <= nxt;
      if (ld_sw)
        stp <= 1'b0;
      else if (ld_prime || ld_ovf)
        stp <= 1'b1;
    end
  end

  always_comb begin
    nxt      = state;
    ld_sw    = 1'b0;
    ld_init  = 1'b0;
    ld_r     = 1'b0;
    ld_sub   = 1'b0;
    ld_incd  = 1'b0;
    ld_nextc = 1'b0;
    ld_prime = 1'b0;
    ld_ovf   = 1'b0;
    unique case (state)
      S_IDLE, S_DONE: begin
        if (go) begin
          ld_sw = 1'b1;
          nxt   = S_INIT;
        end
      end
      S_INIT: begin
        ld_init = 1'b1;
        nxt     = S_CHK;
      end
      S_CHK: begin
        if (prime_hit) begin
          ld_prime = 1'b1;
          nxt      = S_DONE;
        end else begin
          ld_r = 1'b1;
          nxt  = S_REM;
        end
      end
      S_REM: begin
        // d >= 2, so r == 0 can only be seen once r < d
        if (ge)          ld_sub = 1'b1;
        else if (r_zero) nxt    = S_NEXTC;
        else             nxt    = S_NEXTD;
      end
      S_NEXTD: begin
        ld_incd = 1'b1;
        nxt     = S_CHK;
      end
      S_NEXTC: begin
        if (c_max) begin
          ld_ovf = 1'b1;
          nxt    = S_DONE;
        end else begin
          ld_nextc = 1'b1;
          nxt      = S_CHK;
        end
      end
      default: nxt = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE) && (state != S_DONE);

endmodule

// File: rtl/next_prime_dp.sv
// Search datapath: candidate c, divisor d, incremental square dsq, remainder r,
// plus the captured start value and the p/ovf result registers.
module next_prime_dp #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] sw,
  input  logic         ld_sw,
  input  logic         ld_init,
  input  logic         ld_r,
  input  logic         ld_sub,
  input  logic         ld_incd,
  input  logic         ld_nextc,
  input  logic         ld_prime,
  input  logic         ld_ovf,
  output logic         prime_hit,
  output logic         ge,
  output logic         r_zero,
  output logic         c_max,
  output logic [W-1:0] p,
  output logic         ovf
);

  logic [W-1:0] sw_q, c, d, r, r_next;
  logic [W:0]   dsq;

  trial_sub_div #(.W(W)) u_sub (
    .r      (r),
    .d      (d),
    .r_next (r_next),
    .ge     (ge)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_q <= '0;
      c    <= '0;
      d    <= '0;
      dsq  <= '0;
      r    <= '0;
      p    <= '0;
      ovf  <= 1'b0;
    end else begin
      if (ld_sw) begin
        sw_q <= sw;
        ovf  <= 1'b0;
      end
      if (ld_init) begin
        c   <= (sw_q < W'(2)) ? W'(2) : sw_q;
        d   <= W'(2);
        dsq <= (W+1)'(4);
      end
      if (ld_r)   r <= c;
      if (ld_sub) r <= r_next;
      // (d+1)^2 = d^2 + 2d + 1; W+1 bits cannot wrap since d stays near sqrt(c)
      if (ld_incd) begin
        d   <= d + 1'b1;
        dsq <= dsq + {d, 1'b1};
      end
      if (ld_nextc) begin
        c   <= c + 1'b1;
        d   <= W'(2);
        dsq <= (W+1)'(4);
      end
      if (ld_prime) p <= c;
      if (ld_ovf) begin
        p   <= '0;
        ovf <= 1'b1;
      end
    end
  end

  assign prime_hit = (dsq > {1'b0, c});
  assign r_zero    = (r == '0);
  assign c_max     = &c;

endmodule

// File: rtl/trial_sub_div.sv
// Single subtract/compare step of the repeated-subtraction remainder.
// The only W-bit subtractor and comparator on the remainder path.
module trial_sub_div #(
  parameter int W = 16
) (
  input  logic [W-1:0] r,
  input  logic [W-1:0] d,
  output logic [W-1:0] r_next,
  output logic         ge
);

  assign ge     = (r >= d);
  assign r_next = r - d;

endmodule

// File: rtl/next_prime_gen.sv
// Next-prime generator: on go, finds the smallest prime >= sw by trial
// division with repeated subtraction.
module next_prime_gen
  import next_prime_gen_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] sw,
  input  logic         go,
  output logic [W-1:0] p,
  output logic         stp,
  output logic         busy,
  output logic         ovf
);

  logic ld_sw, ld_init, ld_r, ld_sub, ld_incd, ld_nextc, ld_prime, ld_ovf;
  logic prime_hit, ge, r_zero, c_max;

  next_prime_ctrl u_ctrl (
    .clk       (clk),
    .rst       (rst),
    .go        (go),
    .prime_hit (prime_hit),
    .ge        (ge),
    .r_zero    (r_zero),
    .c_max     (c_max),
    .ld_sw     (ld_sw),
    .ld_init   (ld_init),
    .ld_r      (ld_r),
    .ld_sub    (ld_sub),
    .ld_incd   (ld_incd),
    .ld_nextc  (ld_nextc),
    .ld_prime  (ld_prime),
    .ld_ovf    (ld_ovf),
    .stp       (stp),
    .busy      (busy)
  );

  next_prime_dp #(.W(W)) u_dp (
    .clk       (clk),
    .rst       (rst),
    .sw        (sw),
    .ld_sw     (ld_sw),
    .ld_init   (ld_init),
    .ld_r      (ld_r),
    .ld_sub    (ld_sub),
    .ld_incd   (ld_incd),
    .ld_nextc  (ld_nextc),
    .ld_prime  (ld_prime),
    .ld_ovf    (ld_ovf),
    .prime_hit (prime_hit),
    .ge        (ge),
    .r_zero    (r_zero),
    .c_max     (c_max),
    .p         (p),
    .ovf       (ovf)
  );

endmodule

// File: tb/tb_next_prime_gen.sv
// Directed and randomized checks of next_prime_gen against a modulo-based
// reference for "smallest prime >= sw".
module tb_next_prime_gen;
  import next_prime_gen_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] sw  = '0;
  logic        go  = 1'b0;
  logic [15:0] p;
  logic        stp, busy, ovf;

  int ntests = 0;
  int nfail  = 0;

  always #5 clk = ~clk;

  next_prime_gen #(.W(16)) dut (
    .clk  (clk),
    .rst  (rst),
    .sw   (sw),
    .go   (go),
    .p    (p),
    .stp  (stp),
    .busy (busy),
    .ovf  (ovf)
  );

  function automatic bit is_prime(input int n);
    if (n < 2) return 1'b0;
    for (int k = 2; k * k <= n; k++)
      if (n % k == 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void ref_next(input int s, output int rp, output bit rovf);
    rp   = 0;
    rovf = 1'b1;
    for (int n = (s < 2) ? 2 : s; n <= 65535; n++)
      if (is_prime(n)) begin
        rp   = n;
        rovf = 1'b0;
        return;
      end
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present sw with a one-cycle go; returns #1 after the go edge.
  task automatic pulse_go(input int v);
    @(negedge clk);
    sw = 16'(v);
    go = 1'b1;
    @(posedge clk);
    #1;
    go = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int bound);
    int n;
    n = 0;
    while (!stp && n < bound) begin
      @(posedge clk);
      #1;
      n++;
    end
    ntests++;
    if (!stp) begin
      nfail++;
      $error("FAIL %s_timeout: got stp=0 after %0d cycles expected stp=1", tag, n);
    end
  endtask

  task automatic run_one(input string tag, input int v, input int bound);
    int  rp;
    bit  rovf;
    ref_next(v, rp, rovf);
    pulse_go(v);
    wait_done(tag, bound);
    check({tag, "_p"}, 32'(p), 32'(rp));
    check({tag, "_ovf"}, 32'(ovf), 32'(rovf));
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int v;

    // reset state
    #12;
    check("rst_p", 32'(p), 32'd0);
    check("rst_stp", 32'(stp), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // 1: latency for sw=0 -- stp rises after the third edge counting the go edge
    pulse_go(0);
    check("lat_e0_stp", 32'(stp), 32'd0);
    check("lat_e0_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    check("lat_e1_stp", 32'(stp), 32'd0);
    @(posedge clk); #1;
    check("lat_e2_stp", 32'(stp), 32'd1);
    check("lat_p", 32'(p), 32'd2);
    check("lat_ovf", 32'(ovf), 32'd0);
    check("lat_busy", 32'(busy), 32'd0);

    // 2: basic values
    run_one("sw14", 14, 1000);
    check("sw14_lit", 32'(p), 32'd17);
    run_one("sw17", 17, 1000);
    run_one("sw1", 1, 1000);
    check("sw1_lit", 32'(p), 32'd2);

    // 3: top of range
    run_one("sw65522", 65522, 2000000);
    check("ovf_flag", 32'(ovf), 32'd1);
    check("ovf_p", 32'(p), 32'd0);
    run_one("sw65521", 32'(MAX_PRIME16), 1000000);
    check("max_p", 32'(p), 32'd65521);

    // 4: go while busy is ignored
    pulse_go(1000);
    repeat (20) @(posedge clk);
    #1;
    check("busy_mid", 32'(busy), 32'd1);
    pulse_go(5);
    wait_done("ign", 20000);
    check("ign_p", 32'(p), 32'd1009);

    // 5: async reset mid-search
    pulse_go(30000);
    repeat (100) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_p", 32'(p), 32'd0);
    check("arst_stp", 32'(stp), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_one("sw8", 8, 1000);
    check("sw8_lit", 32'(p), 32'd11);

    // 6: back-to-back, stp drops on the accepted go edge
    pulse_go(24);
    check("b2b_stp_drop", 32'(stp), 32'd0);
    wait_done("b2b", 5000);
    check("b2b_p", 32'(p), 32'd29);

    // sweep of small start values, then random samples further up
    for (int i = 0; i <= 150; i++)
      run_one($sformatf("sweep%0d", i), i, 5000);
    for (int i = 0; i < 8; i++) begin
      v = int'($urandom_range(2000, 151));
      run_one($sformatf("rnd%0d", v), v, 20000);
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
